// File: rtl/pc_stack_unit_pkg.sv
// Shared sizing defaults and next-PC select encoding for the PC stage.
package pc_stack_unit_pkg;

    localparam int PC_W_DEF  = 12;
    localparam int OFF_W_DEF = 8;
    localparam int DEPTH_DEF = 8;

    // Next-PC source, in the same encoding the controller uses for its select strobes.
    typedef enum logic [1:0] {
        SEL_INC = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_RET = 2'd3
    } pc_sel_e;

    // Resolve the strobes into one select. An empty-stack return falls
    // through to the incremented PC so stale RAM is never fetched from.
    function automatic pc_sel_e pick_sel(input logic ret, input logic jmp,
                                         input logic branch, input logic empty);
        pc_sel_e sel;
        sel = SEL_INC;
        if (ret) begin
            sel = empty ? SEL_INC : SEL_RET;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (branch) begin
            sel = SEL_BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Controller <-> PC stage bundle: strobes and operands in, fetch address and stack status out.
interface pc_stack_unit_if #(
    parameter int PC_W  = 12,
    parameter int OFF_W = 8,
    parameter int DEPTH = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic              pcEn;
    logic              jmp;
    logic              branch;
    logic              push;
    logic              pop;
    logic              ret;
    logic [PC_W-1:0]   jmpAddr;
    logic [OFF_W-1:0]  brOffset;
    logic [PC_W-1:0]   pc;
    logic [SP_W-1:0]   sp;
    logic              overflow;
    logic              underflow;

    modport master (
        output pcEn, jmp, branch, push, pop, ret, jmpAddr, brOffset,
        input  pc, sp, overflow, underflow
    );

    modport slave (
        input  pcEn, jmp, branch, push, pop, ret, jmpAddr, brOffset,
        output pc, sp, overflow, underflow
    );

endinterface

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address stack: RAM, entry counter, full/empty decode and sticky error flags.
module pc_stack_unit_ret_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8,
    parameter int SP_W  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_ret,
    input  logic [PC_W-1:0] i_wdata,
    output logic [PC_W-1:0] o_tos,
    output logic [SP_W-1:0] o_sp,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_overflow,
    output logic            o_underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0] r_sp;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_illegal;
    logic            w_do_push;
    logic            w_do_pop;
    logic            w_empty;
    logic            w_full;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_top_idx;
    logic [SP_W-1:0] w_sp_m1;

    // push together with pop is rejected outright: no stack change, no flag change
    assign w_illegal  = i_push & i_pop;
    assign w_do_push  = i_en & i_push & ~i_pop;
    assign w_do_pop   = i_en & i_pop & ~i_push;
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == SP_W'(DEPTH));
    assign w_sp_m1    = r_sp - SP_W'(1);
    assign w_wr_idx   = r_sp[AW-1:0];
    assign w_top_idx  = w_sp_m1[AW-1:0];

    // Entry write on a non-full push; RAM is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push && !w_full) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    // Entry counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_sp <= r_sp + SP_W'(1);
                end
            end
            if (w_do_pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_sp <= w_sp_m1;
                end
            end
            if (i_en && i_ret && w_empty && !w_illegal) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Top-of-stack is an asynchronous read so a return resolves in the same cycle.
    assign o_tos       = r_mem[w_top_idx];
    assign o_sp        = r_sp;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_stack_unit.sv
// PC stage: program counter register, next-PC mux/adder and the return-address stack.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_stack_unit_if.slave       bus
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] r_pc;

    logic [PC_W-1:0] w_pc1;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_tos;
    logic [PC_W-1:0] w_next_pc;
    logic [SP_W-1:0] w_sp;
    logic            w_empty;
    logic            w_full;
    logic            w_overflow;
    logic            w_underflow;
    pc_sel_e         w_sel;

    assign w_pc1       = r_pc + PC_W'(1);
    // Offset is relative to the already-incremented PC; sum wraps at PC_W bits.
    assign w_br_target = w_pc1 + PC_W'($signed(bus.brOffset));

    pc_stack_unit_ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .SP_W  (SP_W)
    ) u_ret_stack (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.pcEn),
        .i_push      (bus.push),
        .i_pop       (bus.pop),
        .i_ret       (bus.ret),
        .i_wdata     (w_pc1),
        .o_tos       (w_tos),
        .o_sp        (w_sp),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_overflow  (w_overflow),
        .o_underflow (w_underflow)
    );

    // Next-PC selection: ret over jmp over branch over increment.
    always_comb begin
        w_sel     = pick_sel(bus.ret, bus.jmp, bus.branch, w_empty);
        w_next_pc = w_pc1;
        unique case (w_sel)
            SEL_RET: w_next_pc = w_tos;
            SEL_JMP: w_next_pc = bus.jmpAddr;
            SEL_BR:  w_next_pc = w_br_target;
            default: w_next_pc = w_pc1;
        endcase
    end

    // PC register advances only when the controller enables it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (bus.pcEn) begin
            r_pc <= w_next_pc;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.sp        = w_sp;
    assign bus.overflow  = w_overflow;
    assign bus.underflow = w_underflow;

    // Full is consumed inside the stack; kept visible here for hierarchy probes.
    logic w_full_unused;
    assign w_full_unused = w_full;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed steps queue expected state, a monitor checks each edge.
module tb_pc_stack_unit;
    localparam int PC_W  = 12;
    localparam int OFF_W = 8;
    localparam int DEPTH = 8;
    localparam int SP_W  = $clog2(DEPTH) + 1;

    typedef struct {
        string           name;
        logic [PC_W-1:0] pc;
        logic [SP_W-1:0] sp;
        logic            ov;
        logic            un;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   n_checks;
    int   n_pass;

    pc_stack_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) bus ();

    pc_stack_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce.
    task automatic step(input string nm, input logic r, input logic en,
                        input logic j, input logic b, input logic pu,
                        input logic po, input logic rt,
                        input logic [PC_W-1:0] ja, input logic [OFF_W-1:0] off,
                        input logic [PC_W-1:0] epc, input logic [SP_W-1:0] esp,
                        input logic eov, input logic eun);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.pcEn     = en;
        bus.jmp      = j;
        bus.branch   = b;
        bus.push     = pu;
        bus.pop      = po;
        bus.ret      = rt;
        bus.jmpAddr  = ja;
        bus.brOffset = off;
        e.name = nm;
        e.pc   = epc;
        e.sp   = esp;
        e.ov   = eov;
        e.un   = eun;
        q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare DUT state against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (bus.pc === e.pc && bus.sp === e.sp &&
                bus.overflow === e.ov && bus.underflow === e.un) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got pc=%h sp=%0d ov=%b un=%b, expected pc=%h sp=%0d ov=%b un=%b",
                         e.name, bus.pc, bus.sp, bus.overflow, bus.underflow,
                         e.pc, e.sp, e.ov, e.un);
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.pcEn     = 1'b0;
        bus.jmp      = 1'b0;
        bus.branch   = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.ret      = 1'b0;
        bus.jmpAddr  = '0;
        bus.brOffset = '0;

        //     name       rst en jmp br push pop ret jmpAddr  off     pc       sp ov un
        step("reset0",    1, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0);
        step("reset1",    1, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0);
        step("inc1",      0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h001, 0, 0, 0);
        step("inc2",      0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h002, 0, 0, 0);
        step("inc3",      0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h003, 0, 0, 0);
        step("inc4",      0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h004, 0, 0, 0);
        step("inc5",      0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h005, 0, 0, 0);
        step("call40",    0, 1, 1, 0, 1, 0, 0, 12'h040, 8'h00, 12'h040, 1, 0, 0);
        step("ret6",      0, 1, 0, 0, 0, 1, 1, 12'h000, 8'h00, 12'h006, 0, 0, 0);
        step("jmp10",     0, 1, 1, 0, 0, 0, 0, 12'h010, 8'h00, 12'h010, 0, 0, 0);
        step("br_neg",    0, 1, 0, 1, 0, 0, 0, 12'h000, 8'hFC, 12'h00D, 0, 0, 0);
        step("jmpfff",    0, 1, 1, 0, 0, 0, 0, 12'hFFF, 8'h00, 12'hFFF, 0, 0, 0);
        step("br_wrap",   0, 1, 0, 1, 0, 0, 0, 12'h000, 8'h02, 12'h002, 0, 0, 0);
        step("hold_en0",  0, 0, 1, 0, 0, 0, 0, 12'h123, 8'h00, 12'h002, 0, 0, 0);
        step("jmp0",      0, 1, 1, 0, 0, 0, 0, 12'h000, 8'h00, 12'h000, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step("call_fill", 0, 1, 1, 0, 1, 0, 0, 12'h000, 8'h00, 12'h000,
                 (i < 8) ? SP_W'(i + 1) : SP_W'(8), (i == 8), 0);
        end
        for (int i = 0; i < 8; i++) begin
            step("ret_drain", 0, 1, 0, 0, 0, 1, 1, 12'h000, 8'h00, 12'h001,
                 SP_W'(7 - i), 1, 0);
        end
        step("jmp20",     0, 1, 1, 0, 0, 0, 0, 12'h020, 8'h00, 12'h020, 0, 1, 0);
        step("ret_empty", 0, 1, 0, 0, 0, 1, 1, 12'h000, 8'h00, 12'h021, 0, 1, 1);
        step("sticky",    0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h022, 0, 1, 1);
        step("call100",   0, 1, 1, 0, 1, 0, 0, 12'h100, 8'h00, 12'h100, 1, 1, 1);
        step("push_pop",  0, 1, 0, 0, 1, 1, 0, 12'h000, 8'h00, 12'h101, 1, 1, 1);
        step("ret_peek",  0, 1, 0, 0, 0, 0, 1, 12'h000, 8'h00, 12'h023, 1, 1, 1);
        step("pop_only",  0, 1, 0, 0, 0, 1, 0, 12'h000, 8'h00, 12'h024, 0, 1, 1);
        step("rst_call",  1, 1, 1, 0, 1, 0, 0, 12'h0AA, 8'h00, 12'h000, 0, 0, 0);
        step("inc_after", 0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00, 12'h001, 0, 0, 0);
        step("hold_jmp",  0, 0, 1, 0, 0, 0, 0, 12'h055, 8'h00, 12'h001, 0, 0, 0);
        step("jmp_vs_br", 0, 1, 1, 1, 0, 0, 0, 12'h200, 8'h10, 12'h200, 0, 0, 0);
        step("br_pos",    0, 1, 0, 1, 0, 0, 0, 12'h000, 8'h7F, 12'h280, 0, 0, 0);
        step("callA",     0, 1, 1, 0, 1, 0, 0, 12'h300, 8'h00, 12'h300, 1, 0, 0);
        step("callB",     0, 1, 1, 0, 1, 0, 0, 12'h400, 8'h00, 12'h400, 2, 0, 0);
        step("retB",      0, 1, 0, 0, 0, 1, 1, 12'h000, 8'h00, 12'h301, 1, 0, 0);
        step("retA",      0, 1, 0, 0, 0, 1, 1, 12'h000, 8'h00, 12'h281, 0, 0, 0);

        @(negedge clk);
        bus.pcEn = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
